fifo_drain: RTL

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_drain.sv
// Drains a read-latency-1 FIFO into a valid/ready stream, either a fixed
// number of entries or until the FIFO runs empty, through a 2-entry skid buffer.
module fifo_drain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             fifo_empty,
  input  logic             fifo_we_n,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_oe_n,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] len_q;
  logic             in_flight;
  logic [WIDTH-1:0] buf1;
  logic             buf1_vld;
  logic             pop_c;
  logic             rd_fire_c;
  logic             len_hit_c;
  logic [1:0]       load_c;

  // Occupancy counts the slot freed by this edge's transfer, so a read can be
  // issued every cycle while the stream keeps accepting.
  assign pop_c     = m_valid & m_ready;
  assign load_c    = 2'(m_valid) + 2'(buf1_vld) + 2'(in_flight) - 2'(pop_c);
  assign len_hit_c = (len_q != '0) && (rd_count == len_q);
  assign rd_fire_c = (state == RUN) && !fifo_empty && fifo_we_n && !len_hit_c
                     && (load_c < 2'd2);
  assign fifo_oe_n = ~rd_fire_c;

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (len_hit_c || ((len_q == '0) && fifo_empty && !in_flight))
                 state_nxt = FLUSH;
      FLUSH:   if (load_c == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // State register with registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  // Burst length latch and read counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q    <= '0;
      rd_count <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      len_q    <= burst_len;
      rd_count <= '0;
    end else if (rd_fire_c) begin
      rd_count <= rd_count + CNT_W'(1);
    end
  end

  // In-flight tracking and 2-entry output buffer; m_data/m_valid is the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      buf1_vld  <= 1'b0;
      buf1      <= '0;
    end else if (abort) begin
      in_flight <= 1'b0;
      m_valid   <= 1'b0;
      buf1_vld  <= 1'b0;
    end else begin
      in_flight <= rd_fire_c;
      case ({in_flight, pop_c})
        2'b10: begin
          if (!m_valid) begin
            m_data  <= fifo_dout;
            m_valid <= 1'b1;
          end else begin
            buf1     <= fifo_dout;
            buf1_vld <= 1'b1;
          end
        end
        2'b01: begin
          m_data   <= buf1;
          m_valid  <= buf1_vld;
          buf1_vld <= 1'b0;
        end
        2'b11: begin
          if (buf1_vld) begin
            m_data <= buf1;
            buf1   <= fifo_dout;
          end else begin
            m_data <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
